// File: rtl/pwm_phased_burst.sv
// -----------------------------------------------------------------------------
// pwm_phased_burst
//
// Purpose:
//   Emits a burst of N PWM pulses on each of NUM_CHANNELS outputs. Every
//   channel starts after its own phase delay. The burst ends when every channel
//   has produced its N pulses, or earlier on abort. A one-cycle done pulse marks
//   the end of every burst.
//
// Ports:
//   clk_in           in   1             system clock (rising edge)
//   rst_n_in         in   1             asynchronous active-low reset
//   start_in         in   1             burst request, sampled only in IDLE
//   abort_in         in   1             terminate a running burst
//   num_pulses_in    in   PW            pulses per channel for the burst
//   phase_offset_in  in   NUM_CHANNELS*CW  per-channel start delay, ch i at [i*CW +: CW]
//   sig_out          out  NUM_CHANNELS  registered PWM outputs
//   busy_out         out  1             high while a burst runs
//   done_out         out  1             one-cycle pulse at the end of each burst
//   chan_en_in       in   NUM_CHANNELS  per-channel enable, latched at start
//                                       (present only with the macro below)
//
// Configuration macro:
//   PWM_PHASED_BURST_CHAN_MASK_EN - adds chan_en_in. A masked channel stays low
//   and counts as finished from the start of the burst.
// -----------------------------------------------------------------------------
module pwm_phased_burst #(
    parameter int NUM_CHANNELS           = 4,
    parameter int PERIOD_IN_CLOCK_CYCLES = 2500,
    parameter int DUTY_CYCLE_ON          = 1250,
    parameter int MAX_PULSES             = 255,
    localparam int PW = $clog2(MAX_PULSES + 1),
    localparam int CW = $clog2(PERIOD_IN_CLOCK_CYCLES)
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       start_in,
    input  logic                       abort_in,
    input  logic [PW-1:0]              num_pulses_in,
    input  logic [NUM_CHANNELS*CW-1:0] phase_offset_in,
    output logic [NUM_CHANNELS-1:0]    sig_out,
    output logic                       busy_out,
    output logic                       done_out
`ifdef PWM_PHASED_BURST_CHAN_MASK_EN
    ,
    input  logic [NUM_CHANNELS-1:0]    chan_en_in
`endif
);

    localparam logic [CW-1:0] PER_MAX    = CW'(PERIOD_IN_CLOCK_CYCLES - 1);
    localparam logic [CW:0]   PERIOD_EXT = (CW+1)'(PERIOD_IN_CLOCK_CYCLES);
    localparam logic [CW-1:0] DUTY_C     = CW'(DUTY_CYCLE_ON);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_r;
    logic [NUM_CHANNELS-1:0] sig_r;
    logic                    busy_r;
    logic                    done_r;

    // Per-channel registers: remaining delay, position in period, remaining
    // pulses (including the one in progress), active and finished flags.
    logic [CW-1:0]           dly_r [NUM_CHANNELS];
    logic [CW-1:0]           per_r [NUM_CHANNELS];
    logic [PW-1:0]           rem_r [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] act_r;
    logic [NUM_CHANNELS-1:0] fin_r;

    // Values loaded on the accepted start edge.
    logic [NUM_CHANNELS-1:0] en_s;
    logic [CW-1:0]           ini_dly_s [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] ini_act_s;
    logic [NUM_CHANNELS-1:0] ini_fin_s;
    logic [NUM_CHANNELS-1:0] ini_sig_s;

    // Values for the next RUN cycle.
    logic [CW-1:0]           dly_s [NUM_CHANNELS];
    logic [CW-1:0]           per_s [NUM_CHANNELS];
    logic [PW-1:0]           rem_s [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] act_s;
    logic [NUM_CHANNELS-1:0] fin_s;
    logic [NUM_CHANNELS-1:0] sig_s;
    logic                    all_fin_s;

`ifdef PWM_PHASED_BURST_CHAN_MASK_EN
    assign en_s = chan_en_in;
`else
    assign en_s = {NUM_CHANNELS{1'b1}};
`endif

    // Start-edge load values: clamp offsets and decide which channels go high
    // in the very first RUN cycle (zero offset).
    always_comb begin
        logic [CW-1:0] raw;
        logic [CW-1:0] clamped;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            raw = phase_offset_in[i*CW +: CW];
            if ({1'b0, raw} >= PERIOD_EXT) begin
                clamped = PER_MAX;
            end else begin
                clamped = raw;
            end
            ini_dly_s[i] = clamped;
            if (!en_s[i]) begin
                ini_act_s[i] = 1'b0;
                ini_fin_s[i] = 1'b1;
                ini_sig_s[i] = 1'b0;
            end else if (clamped == {CW{1'b0}}) begin
                // Zero delay: the pulse train starts in the first RUN cycle.
                ini_act_s[i] = 1'b1;
                ini_fin_s[i] = 1'b0;
                ini_sig_s[i] = 1'b1;
            end else begin
                ini_act_s[i] = 1'b0;
                ini_fin_s[i] = 1'b0;
                ini_sig_s[i] = 1'b0;
            end
        end
    end

    // Per-channel advance for one RUN cycle: count down the delay, then walk
    // the period counter and retire pulses until none remain.
    always_comb begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            dly_s[i] = dly_r[i];
            per_s[i] = per_r[i];
            rem_s[i] = rem_r[i];
            act_s[i] = act_r[i];
            fin_s[i] = fin_r[i];
            sig_s[i] = 1'b0;
            if (fin_r[i]) begin
                act_s[i] = 1'b0;
            end else if (act_r[i]) begin
                if (per_r[i] == PER_MAX) begin
                    if (rem_r[i] <= PW'(1)) begin
                        // Last pulse just completed.
                        act_s[i] = 1'b0;
                        fin_s[i] = 1'b1;
                        per_s[i] = {CW{1'b0}};
                    end else begin
                        rem_s[i] = rem_r[i] - PW'(1);
                        per_s[i] = {CW{1'b0}};
                        sig_s[i] = 1'b1;
                    end
                end else begin
                    per_s[i] = per_r[i] + CW'(1);
                    sig_s[i] = ((per_r[i] + CW'(1)) < DUTY_C);
                end
            end else begin
                // A delay of d activates the channel on the d-th edge after start.
                if (dly_r[i] <= CW'(1)) begin
                    dly_s[i] = {CW{1'b0}};
                    act_s[i] = 1'b1;
                    per_s[i] = {CW{1'b0}};
                    sig_s[i] = 1'b1;
                end else begin
                    dly_s[i] = dly_r[i] - CW'(1);
                end
            end
        end
        all_fin_s = &fin_s;
    end

    // Burst FSM with registered outputs and channel counters.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r <= ST_IDLE;
            sig_r   <= {NUM_CHANNELS{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            act_r   <= {NUM_CHANNELS{1'b0}};
            fin_r   <= {NUM_CHANNELS{1'b0}};
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                dly_r[i] <= {CW{1'b0}};
                per_r[i] <= {CW{1'b0}};
                rem_r[i] <= {PW{1'b0}};
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    sig_r  <= {NUM_CHANNELS{1'b0}};
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    if (start_in) begin
                        if (num_pulses_in == {PW{1'b0}}) begin
                            // Zero-length burst goes straight to DONE.
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                            act_r   <= {NUM_CHANNELS{1'b0}};
                            fin_r   <= {NUM_CHANNELS{1'b1}};
                        end else begin
                            state_r <= ST_RUN;
                            busy_r  <= 1'b1;
                            sig_r   <= ini_sig_s;
                            act_r   <= ini_act_s;
                            fin_r   <= ini_fin_s;
                            for (int i = 0; i < NUM_CHANNELS; i++) begin
                                dly_r[i] <= ini_dly_s[i];
                                per_r[i] <= {CW{1'b0}};
                                rem_r[i] <= num_pulses_in;
                            end
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (abort_in) begin
                        // Abort wins over everything, including a new start.
                        state_r <= ST_DONE;
                        sig_r   <= {NUM_CHANNELS{1'b0}};
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        act_r   <= {NUM_CHANNELS{1'b0}};
                        fin_r   <= {NUM_CHANNELS{1'b1}};
                    end else begin
                        sig_r <= sig_s;
                        act_r <= act_s;
                        fin_r <= fin_s;
                        for (int i = 0; i < NUM_CHANNELS; i++) begin
                            dly_r[i] <= dly_s[i];
                            per_r[i] <= per_s[i];
                            rem_r[i] <= rem_s[i];
                        end
                        if (all_fin_s) begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_RUN;
                            busy_r  <= 1'b1;
                            done_r  <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    sig_r   <= {NUM_CHANNELS{1'b0}};
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    sig_r   <= {NUM_CHANNELS{1'b0}};
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    act_r   <= {NUM_CHANNELS{1'b0}};
                    fin_r   <= {NUM_CHANNELS{1'b0}};
                end
            endcase
        end
    end

    assign sig_out  = sig_r;
    assign busy_out = busy_r;
    assign done_out = done_r;

endmodule

// File: tb/tb_pwm_phased_burst.sv
// -----------------------------------------------------------------------------
// tb_pwm_phased_burst
//
// Directed bench for pwm_phased_burst with NUM_CHANNELS=4, PERIOD=10, DUTY=5,
// MAX_PULSES=15 (PW=4, CW=4). Cycle c denotes the clock cycle following
// edge c-1; a start accepted at edge 0 makes cycle 1 the first RUN cycle.
// -----------------------------------------------------------------------------
module tb_pwm_phased_burst;

    localparam int NC = 4;
    localparam int P  = 10;
    localparam int D  = 5;
    localparam int MP = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  num = 4'd0;
    logic [15:0] offs = 16'h0000;
    logic [3:0]  sig;
    logic        busy;
    logic        done;
`ifdef PWM_PHASED_BURST_CHAN_MASK_EN
    logic [3:0]  chan_en = 4'hF;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    pwm_phased_burst #(
        .NUM_CHANNELS(NC),
        .PERIOD_IN_CLOCK_CYCLES(P),
        .DUTY_CYCLE_ON(D),
        .MAX_PULSES(MP)
    ) dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .start_in(start),
        .abort_in(abort),
        .num_pulses_in(num),
        .phase_offset_in(offs),
        .sig_out(sig),
        .busy_out(busy),
        .done_out(done)
`ifdef PWM_PHASED_BURST_CHAN_MASK_EN
        ,
        .chan_en_in(chan_en)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs from the channel rule: channel i with clamped offset d
    // is high in cycles [1+d, 1+d+n*P) whenever (c-1-d) mod P < D.
    function automatic logic [3:0] exp_sig(input int c, input logic [15:0] o,
                                           input int n, input logic [3:0] mask);
        logic [3:0] r;
        logic [3:0] raw;
        int d;
        r = 4'b0000;
        for (int i = 0; i < NC; i++) begin
            raw = o[i*4 +: 4];
            d = int'(raw);
            if (d >= P) d = P - 1;
            if (mask[i] && c >= 1 + d && c < 1 + d + n * P && ((c - 1 - d) % P) < D)
                r[i] = 1'b1;
        end
        return r;
    endfunction

    // Start a burst at the next edge, scramble the inputs during RUN, and check
    // every cycle through RUN, the DONE pulse and the first IDLE cycle.
    task automatic run_burst(input int sc, input logic [15:0] o, input logic [3:0] n,
                             input logic [3:0] mask, input int busy_len);
        offs  = o;
        num   = n;
`ifdef PWM_PHASED_BURST_CHAN_MASK_EN
        chan_en = mask;
`endif
        start = 1'b1;
        step();
        start = 1'b0;
        offs  = 16'h0000;
        num   = 4'd15;
`ifdef PWM_PHASED_BURST_CHAN_MASK_EN
        chan_en = 4'hF;
`endif
        for (int c = 1; c <= busy_len + 2; c++) begin
            check($sformatf("s%0d_sig_c%0d", sc, c), {28'd0, sig}, {28'd0, exp_sig(c, o, int'(n), mask)});
            check($sformatf("s%0d_busy_c%0d", sc, c), {31'd0, busy}, {31'd0, (c <= busy_len)});
            check($sformatf("s%0d_done_c%0d", sc, c), {31'd0, done}, {31'd0, (c == busy_len + 1)});
            step();
        end
    endtask

    initial begin
        // Reset state
        step();
        step();
        check("rst_sig", {28'd0, sig}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;

        // Scenario 1: offsets all zero, N=2, start on first edge after reset
        run_burst(1, 16'h0000, 4'd2, 4'hF, 20);

        // Scenario 2: offsets {0,3,6,9}, N=1
        run_burst(2, 16'h9630, 4'd1, 4'hF, 19);

        // Offset 15 on channel 3 clamps to 9
        run_burst(7, 16'hF000, 4'd1, 4'hF, 19);

        // Scenario 3: zero-length burst
        num   = 4'd0;
        offs  = 16'h0000;
        start = 1'b1;
        step();
        start = 1'b0;
        check("s3_sig_c1", {28'd0, sig}, 32'd0);
        check("s3_busy_c1", {31'd0, busy}, 32'd0);
        check("s3_done_c1", {31'd0, done}, 32'd1);
        step();
        check("s3_sig_c2", {28'd0, sig}, 32'd0);
        check("s3_busy_c2", {31'd0, busy}, 32'd0);
        check("s3_done_c2", {31'd0, done}, 32'd0);

        // Abort together with start in IDLE is ignored; abort in RUN ends it
        num   = 4'd1;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("ia_busy_c1", {31'd0, busy}, 32'd1);
        check("ia_sig_c1", {28'd0, sig}, 32'hF);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("ia_sig_c2", {28'd0, sig}, 32'd0);
        check("ia_busy_c2", {31'd0, busy}, 32'd0);
        check("ia_done_c2", {31'd0, done}, 32'd1);
        step();
        check("ia_done_c3", {31'd0, done}, 32'd0);

        // Scenario 4: N=3, abort plus start during cycle 8
        num   = 4'd3;
        offs  = 16'h0000;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("s4_sig_c%0d", c), {28'd0, sig}, {28'd0, exp_sig(c, 16'h0000, 3, 4'hF)});
            check($sformatf("s4_busy_c%0d", c), {31'd0, busy}, 32'd1);
            if (c == 8) begin
                abort = 1'b1;
                start = 1'b1;
            end
            step();
        end
        check("s4_sig_c9", {28'd0, sig}, 32'd0);
        check("s4_busy_c9", {31'd0, busy}, 32'd0);
        check("s4_done_c9", {31'd0, done}, 32'd1);
        abort = 1'b0;
        step();
        start = 1'b0;
        check("s4_busy_c10", {31'd0, busy}, 32'd0);
        check("s4_done_c10", {31'd0, done}, 32'd0);
        step();
        check("s4_busy_c11", {31'd0, busy}, 32'd0);
        check("s4_sig_c11", {28'd0, sig}, 32'd0);

        // Scenario 5: reset in cycle 6 of a burst (channel 3 high there)
        num   = 4'd2;
        offs  = 16'h3000;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 5; c++) step();
        check("s5_sig_c6", {28'd0, sig}, 32'h8);
        check("s5_busy_c6", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("s5_async_sig", {28'd0, sig}, 32'd0);
        check("s5_async_busy", {31'd0, busy}, 32'd0);
        check("s5_async_done", {31'd0, done}, 32'd0);
        step();
        check("s5_held_sig", {28'd0, sig}, 32'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("s5_nodone_%0d", c), {31'd0, done}, 32'd0);
            check($sformatf("s5_idle_busy_%0d", c), {31'd0, busy}, 32'd0);
        end
        run_burst(5, 16'h0000, 4'd1, 4'hF, 10);

`ifdef PWM_PHASED_BURST_CHAN_MASK_EN
        // Scenario 6: channels 1 and 3 masked; channel 3's offset 9 is ignored
        run_burst(6, 16'h9000, 4'd1, 4'b0101, 10);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/pwm_phased_burst.md
PWM_PHASED_BURST -- requirements
Module: pwm_phased_burst

Interface
REQ-001 Parameter NUM_CHANNELS, default 4: number of independent PWM output channels.
REQ-002 Parameter PERIOD_IN_CLOCK_CYCLES, default 2500: one carrier period (40 kHz at 100 MHz).
REQ-003 Parameter DUTY_CYCLE_ON, default 1250: high cycles per period; legal range 1..PERIOD_IN_CLOCK_CYCLES-1.
REQ-004 Parameter MAX_PULSES, default 255: maximum pulses per burst; PW = $clog2(MAX_PULSES+1), CW = $clog2(PERIOD_IN_CLOCK_CYCLES).
REQ-005 The block has one clock and an asynchronous, active-low reset.
REQ-006 clk_in  input  1: system clock; all state changes on its rising edge.
REQ-007 rst_n_in  input  1: asynchronous, active-low reset.
REQ-008 start_in  input  1: burst request; sampled only in IDLE.
REQ-009 abort_in  input  1: terminate a running burst.
REQ-010 num_pulses_in  input  PW: pulses per channel for the requested burst.
REQ-011 phase_offset_in  input  NUM_CHANNELS*CW: per-channel start delay in clocks; channel i occupies bits [i*CW +: CW].
REQ-012 sig_out  output  NUM_CHANNELS: registered PWM outputs.
REQ-013 busy_out  output  1: high while in RUN.
REQ-014 done_out  output  1: one-cycle pulse at the end of every burst, including aborted and zero-length bursts.

Function
REQ-015 The FSM has states IDLE, RUN, DONE; IDLE->RUN on start_in with num_pulses_in!=0; IDLE->DONE on start_in with num_pulses_in==0; RUN->DONE when all channels finish or on abort_in; DONE->IDLE unconditionally after one cycle.
REQ-016 On the accepted start edge k, the block latches num_pulses_in and every phase offset; changes to these inputs during RUN have no effect.
REQ-017 An offset >= PERIOD_IN_CLOCK_CYCLES is clamped to PERIOD_IN_CLOCK_CYCLES-1 at latch time.
REQ-018 Each channel is a per-channel delay counter, period counter (0..PERIOD-1, wraps) and pulse counter.
REQ-019 Channel i with offset d drives sig_out[i] high first in cycle k+1+d, with high while period count < DUTY_CYCLE_ON.
REQ-020 Channel i emits exactly N latched pulses, then holds sig_out[i] low and flags finished.
REQ-021 RUN lasts max(d_i)+N*PERIOD_IN_CLOCK_CYCLES cycles; DONE, with done_out=1, occupies the following cycle.
REQ-022 abort_in in RUN forces all sig_out low at the next edge, and the FSM enters DONE.
REQ-023 abort_in with start_in in RUN: abort wins. abort_in in IDLE or DONE: ignored.
REQ-024 start_in in RUN or DONE is ignored and not queued.
REQ-025 busy_out=1 exactly in RUN; sig_out is 0 in IDLE and DONE.

Reset
REQ-026 Asserting rst_n_in low immediately forces IDLE, sig_out=0, busy_out=0, done_out=0 and clears all counters.
REQ-027 Reset mid-burst discards the burst and does not produce a done_out pulse.
REQ-028 Reset deassertion is synchronised externally; the first accepted start is on the first edge with rst_n_in high.

Configuration
REQ-029 Macro PWM_PHASED_BURST_CHAN_MASK_EN, when defined, adds port chan_en_in (input, NUM_CHANNELS), latched with the offsets at start.
REQ-030 With the macro, a masked channel holds sig_out[i]=0, counts as finished immediately, and is excluded from the RUN-length max.
REQ-031 Without the macro, the port is absent and all channels are enabled.

Verification (NUM_CHANNELS=4, PERIOD=10, DUTY=5, MAX_PULSES=15)
REQ-032 Scenario 1: offsets {0,0,0,0}, N=2, start at edge 0 -> all sig_out high cycles 1-5 and 11-15, busy_out high cycles 1-20, done_out high in cycle 21.
REQ-033 Scenario 2: offsets {0,3,6,9}, N=1 -> channel 2 high cycles 7-11, busy_out high for 19 cycles, single done_out pulse.
REQ-034 Scenario 3: N=0 start -> no sig_out activity, busy_out stays 0, done_out pulses the cycle after start.
REQ-035 Scenario 4: N=3, abort_in in cycle 8 -> sig_out all 0 and done_out=1 next cycle; start_in asserted with the abort is ignored.
REQ-036 Scenario 5: rst_n_in low in cycle 6 of a burst -> outputs 0 asynchronously, no done_out; a new start after release runs normally.
REQ-037 Scenario 6 (macro on): chan_en_in=4'b0101, offsets {0,0,0,9}, N=1 -> channels 1 and 3 stay low and RUN lasts 10 cycles.
